// File: rtl/helix4_die_core.sv
// helix4_die_core: single-lane perceive/reason/act/learn engine.
// One user word is folded into a context shift register. A thought vector
// {fb, ctx} is then formed and one action word is emitted. The engine waits
// for one world-feedback word, which updates the feedback accumulator, before
// it accepts the next user word.
// Optional build macro: HELIX4_ACTION_SAT_EN -- when defined, the action word
// saturates at all-ones instead of wrapping.
module helix4_die_core #(
  parameter int INPUT_W    = 32,
  parameter int CONTEXT_W  = 64,
  parameter int THOUGHT_W  = 96,
  parameter int ACTION_W   = 24,
  parameter int FEEDBACK_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                user_valid,
  output logic                user_ready,
  input  logic [INPUT_W-1:0]  user_data,
  input  logic                world_valid,
  output logic                world_ready,
  input  logic [ACTION_W-1:0] world_data,
  output logic                action_valid,
  input  logic                action_ready,
  output logic [ACTION_W-1:0] action_data
);

  // The action sum is wide enough that it can never overflow.
  localparam int SUM_W = ((INPUT_W > FEEDBACK_W) ? INPUT_W : FEEDBACK_W) + 1;

  typedef enum logic [1:0] {IDLE, REASON, ACT, LEARN} state_e;

  state_e                state_q, state_d;
  logic [CONTEXT_W-1:0]  ctx_q, ctx_d;
  logic [FEEDBACK_W-1:0] fb_q, fb_d;
  logic [THOUGHT_W-1:0]  thought_q, thought_d;
  logic [ACTION_W-1:0]   act_q, act_d;

  logic [CONTEXT_W-1:0]  ctx_shift;
  logic [SUM_W-1:0]      act_sum;
  logic [ACTION_W-1:0]   act_val;
  logic [FEEDBACK_W:0]   fb_sum;

  // The new user word enters at the LSB end; older words move up.
  generate
    if (CONTEXT_W > INPUT_W) begin : g_ctx_shift
      assign ctx_shift = {ctx_q[CONTEXT_W-INPUT_W-1:0], user_data};
    end else begin : g_ctx_load
      assign ctx_shift = user_data;
    end
  endgenerate

  // Action function: the newest context word plus the feedback, then reduced to ACTION_W bits.
  always_comb begin
    act_sum = SUM_W'(ctx_q[INPUT_W-1:0]) + SUM_W'(fb_q);
`ifdef HELIX4_ACTION_SAT_EN
    act_val = (|act_sum[SUM_W-1:ACTION_W]) ? {ACTION_W{1'b1}} : act_sum[ACTION_W-1:0];
`else
    act_val = act_sum[ACTION_W-1:0];
`endif
  end

  // Feedback update: the average of the old feedback and the world word.
  // The extra bit keeps the carry.
  assign fb_sum = {1'b0, fb_q} + (FEEDBACK_W+1)'(world_data);

  // Next-state, datapath updates and handshake decode. The handshake outputs
  // are decoded from registered state and are held low during reset.
  always_comb begin
    state_d      = state_q;
    ctx_d        = ctx_q;
    fb_d         = fb_q;
    thought_d    = thought_q;
    act_d        = act_q;
    user_ready   = 1'b0;
    world_ready  = 1'b0;
    action_valid = 1'b0;
    case (state_q)
      IDLE: begin
        user_ready = rst_n;
        if (user_valid) begin
          ctx_d   = ctx_shift;
          state_d = REASON;
        end
      end
      REASON: begin
        thought_d = {fb_q, ctx_q};
        act_d     = act_val;
        state_d   = ACT;
      end
      ACT: begin
        action_valid = rst_n;
        if (action_ready) state_d = LEARN;
      end
      LEARN: begin
        world_ready = rst_n;
        if (world_valid) begin
          fb_d    = fb_sum[FEEDBACK_W:1];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any pending action.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ctx_q     <= '0;
      fb_q      <= '0;
      thought_q <= '0;
      act_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctx_q     <= ctx_d;
      fb_q      <= fb_d;
      thought_q <= thought_d;
      act_q     <= act_d;
    end
  end

  assign action_data = act_q;

endmodule

// File: tb/tb_helix4_die_core.sv
// Self-checking bench for helix4_die_core: directed cases plus randomized
// loops, compared against a plain-arithmetic reference model.
module tb_helix4_die_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        user_valid = 1'b0;
  logic        user_ready;
  logic [31:0] user_data = '0;
  logic        world_valid = 1'b0;
  logic        world_ready;
  logic [23:0] world_data = '0;
  logic        action_valid;
  logic        action_ready = 1'b0;
  logic [23:0] action_data;

  int nerr = 0;
  int nchk = 0;
  int nact = 0;

  logic [63:0] m_ctx = '0;
  logic [31:0] m_fb  = '0;
  logic [23:0] last_act;

  helix4_die_core dut (
    .clk(clk), .rst_n(rst_n),
    .user_valid(user_valid), .user_ready(user_ready), .user_data(user_data),
    .world_valid(world_valid), .world_ready(world_ready), .world_data(world_data),
    .action_valid(action_valid), .action_ready(action_ready), .action_data(action_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && action_valid && action_ready) nact <= nact + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference action: plain sum, then saturate or wrap to 24 bits.
  function automatic logic [23:0] ref_act(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] s;
    s = 64'(a) + 64'(b);
`ifdef HELIX4_ACTION_SAT_EN
    if (s > 64'hFF_FFFF) return 24'hFF_FFFF;
`endif
    return s[23:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_user_ready", user_ready, 0);
    chk("rst_world_ready", world_ready, 0);
    chk("rst_action_valid", action_valid, 0);
    @(posedge clk); #1;
    chk("rst_action_data", action_data, 0);
    chk("rst_fb", dut.fb_q, 0);
    @(negedge clk); rst_n = 1'b1;
    m_ctx = '0; m_fb = '0;
    @(posedge clk); #1;
    chk("post_rst_user_ready", user_ready, 1);
  endtask

  // One full loop: user word, action (held for ad cycles), world word
  // (delayed wd cycles, or offered early from the start).
  task automatic txn(input logic [31:0] u, input logic [23:0] w,
                     input int ad, input int wd, input bit early);
    int t;
    logic [23:0] ea;
    logic [95:0] et;
    m_ctx = {m_ctx[31:0], u};
    ea = ref_act(u, m_fb);
    et = {m_fb, m_ctx};
    user_data = u; user_valid = 1'b1;
    if (early) begin world_valid = 1'b1; world_data = w; end
    t = 0;
    while (!user_ready && t < 20) begin @(posedge clk); #1; t++; end
    chk("user_ready", user_ready, 1);
    @(posedge clk); #1;
    user_valid = 1'b0; user_data = $urandom;
    chk("reason_valid_low", action_valid, 0);
    chk("reason_world_ready", world_ready, 0);
    @(posedge clk); #1;
    chk("act_valid", action_valid, 1);
    chk("act_data", action_data, ea);
    chk("thought", dut.thought_q, et);
    last_act = action_data;
    repeat (ad) begin
      @(posedge clk); #1;
      chk("hold_valid", action_valid, 1);
      chk("hold_data", action_data, ea);
      chk("hold_user_ready", user_ready, 0);
      chk("hold_world_ready", world_ready, 0);
      chk("hold_fb", dut.fb_q, m_fb);
    end
    action_ready = 1'b1;
    @(posedge clk); #1;
    action_ready = 1'b0;
    chk("learn_world_ready", world_ready, 1);
    chk("learn_valid_low", action_valid, 0);
    chk("learn_fb", dut.fb_q, m_fb);
    if (!early) begin
      repeat (wd) begin
        @(posedge clk); #1;
        chk("learn_wait_ready", world_ready, 1);
      end
      world_valid = 1'b1; world_data = w;
    end
    @(posedge clk); #1;
    world_valid = 1'b0;
    m_fb = (m_fb + 32'(w)) >> 1;
    chk("idle_user_ready", user_ready, 1);
    chk("fb", dut.fb_q, m_fb);
  endtask

  initial begin
    int a0;
    #2;
    do_reset();

    // World word offered before any user word is back-pressured.
    world_valid = 1'b1; world_data = 24'd7;
    repeat (5) begin
      @(posedge clk); #1;
      chk("early_world_ready", world_ready, 0);
      chk("early_fb", dut.fb_q, 0);
    end
    txn(32'd1, 24'd7, 2, 0, 1'b1);
    txn(32'd2, 24'd9, 0, 1, 1'b0);
    chk("thought_lo", dut.thought_q[63:0], 64'h0000_0001_0000_0002);

    // Directed loop with partners always ready.
    do_reset();
    a0 = nact;
    txn(32'd25, 24'd50, 0, 0, 1'b0);
    chk("dir_act0", last_act, 24'd25);
    txn(32'd125, 24'd30, 0, 0, 1'b0);
    chk("dir_act1", last_act, 24'd150);
    txn(32'd55, 24'd10, 0, 0, 1'b0);
    chk("dir_act2", last_act, 24'd82);
    chk("dir_fb", dut.fb_q, 32'd18);
    chk("dir_nact", 32'(nact - a0), 32'd3);

    // Action held off for 10 cycles.
    txn(32'd9, 24'd4, 10, 0, 1'b0);

    // Drive fb toward the top of its reachable range, then overflow the action sum.
    for (int i = 0; i < 30; i++) txn(32'd0, 24'hFF_FFFF, 0, 0, 1'b0);
    chk("sat_fb", dut.fb_q, 32'h00FF_FFFE);
    txn(32'h00FF_FFFF, 24'd0, 0, 0, 1'b0);
`ifdef HELIX4_ACTION_SAT_EN
    chk("sat_act", last_act, 24'hFF_FFFF);
`else
    chk("wrap_act", last_act, 24'hFF_FFFD);
`endif

    // Reset while an action is pending.
    user_data = 32'd77; user_valid = 1'b1;
    @(posedge clk); #1; user_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_act_valid", action_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_act_valid", action_valid, 0);
    chk("mid_rst_user_ready", user_ready, 0);
    @(posedge clk); #1;
    chk("mid_rst_fb", dut.fb_q, 0);
    chk("mid_rst_thought", dut.thought_q, 0);
    @(negedge clk); rst_n = 1'b1;
    m_ctx = '0; m_fb = '0;
    @(posedge clk); #1;
    txn(32'd25, 24'd3, 0, 0, 1'b0);
    chk("post_rst_act", last_act, 24'd25);

    // Randomized loops.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] u;
      logic [23:0] w;
      u = (i % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      w = 24'($urandom);
      txn(u, w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
